// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  // Ceiling log2 for sizing counters and addresses from a depth.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Number of entries addressed by an ADDR_WIDTH-bit index.
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered synchronous read.
// The read data register is reset; the array itself is not.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array write; no reset so it maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count, status flags,
// flush, and optional sticky overflow/underflow flags (macro FIFO_ERR_EN).
// Writes when full and reads when empty are dropped, never overwritten/re-read.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rest,
  input  logic                  i_flush,
  input  logic                  i_wen,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ren,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_afull,
  output logic                  o_aempty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_ovf,
  output logic                  o_udf
);

  localparam int                DEPTH     = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] LP_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] LP_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] LP_ONE    = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0] r_wptr, r_rptr, r_count;
  logic                r_valid;
  logic                w_full, w_empty, w_wr_ok, w_rd_ok;
  logic                w_unused_msb;

  // Flags come straight from the registered count.
  assign w_full   = (r_count == LP_DEPTH);
  assign w_empty  = (r_count == '0);
  // Flush outranks both requests; empty blocks a read even with a write pending.
  assign w_wr_ok  = i_wen & ~w_full  & ~i_flush;
  assign w_rd_ok  = i_ren & ~w_empty & ~i_flush;

  // Wrap bits are kept for the pointer format but not needed for addressing.
  assign w_unused_msb = &{1'b0, r_wptr[ADDR_WIDTH], r_rptr[ADDR_WIDTH]};

  // Pointer and occupancy update; flush returns everything to the empty state.
  always_ff @(posedge i_clk or posedge i_rest) begin
    if (i_rest) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + LP_ONE;
      if (w_rd_ok) r_rptr <= r_rptr + LP_ONE;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // o_valid marks a read accepted on the previous edge.
  always_ff @(posedge i_clk or posedge i_rest) begin
    if (i_rest) r_valid <= 1'b0;
    else        r_valid <= w_rd_ok;
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rest),
    .i_we    (w_wr_ok),
    .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata (i_data),
    .i_re    (w_rd_ok),
    .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata (o_data)
  );

  assign o_valid  = r_valid;
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_afull  = (r_count >= LP_AFULL);
  assign o_aempty = (r_count <= LP_AEMPTY);
  assign o_count  = r_count;

`ifdef FIFO_ERR_EN
  logic r_ovf, r_udf;

  // Sticky error flags; only reset clears them, flush does not.
  always_ff @(posedge i_clk or posedge i_rest) begin
    if (i_rest) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (i_wen & w_full  & ~i_flush) r_ovf <= 1'b1;
      if (i_ren & w_empty & ~i_flush) r_udf <= 1'b1;
    end
  end

  assign o_ovf = r_ovf;
  assign o_udf = r_udf;
`else
  assign o_ovf = 1'b0;
  assign o_udf = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: a queue-based model predicts each
// accepted read; a negedge monitor pops and checks data and all flags.
module tb_sync_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic          i_clk = 1'b0;
  logic          i_rest = 1'b1;
  logic          i_flush = 1'b0;
  logic          i_wen = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_ren = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid, o_full, o_empty, o_afull, o_aempty, o_ovf, o_udf;
  logic [AW:0]   o_count;

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .i_clk(i_clk), .i_rest(i_rest), .i_flush(i_flush), .i_wen(i_wen),
    .i_data(i_data), .i_ren(i_ren), .o_data(o_data), .o_valid(o_valid),
    .o_full(o_full), .o_empty(o_empty), .o_afull(o_afull), .o_aempty(o_aempty),
    .o_count(o_count), .o_ovf(o_ovf), .o_udf(o_udf)
  );

  always #5 i_clk = ~i_clk;

  // Reference model state
  int       n_tests = 0;
  int       n_fail  = 0;
  bit [7:0] mq[$];      // FIFO contents
  bit [7:0] sb[$];      // expected read data, consumed by the monitor
  bit [7:0] m_data = 0;
  bit       m_valid = 0;
  bit       m_ovf = 0, m_udf = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit err_on();
`ifdef FIFO_ERR_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete(); sb.delete();
    m_data = 0; m_valid = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic chk_state(input string tag);
    int c;
    c = mq.size();
    chk({tag, ".count"},  int'(o_count),  c);
    chk({tag, ".empty"},  int'(o_empty),  int'(c == 0));
    chk({tag, ".full"},   int'(o_full),   int'(c == DEPTH));
    chk({tag, ".afull"},  int'(o_afull),  int'(c >= AF));
    chk({tag, ".aempty"}, int'(o_aempty), int'(c <= AE));
    chk({tag, ".valid"},  int'(o_valid),  int'(m_valid));
    chk({tag, ".data"},   int'(o_data),   int'(m_data));
    chk({tag, ".ovf"},    int'(o_ovf),    int'(m_ovf & err_on()));
    chk({tag, ".udf"},    int'(o_udf),    int'(m_udf & err_on()));
  endtask

  // One clock of stimulus; the model advances on the same edge.
  task automatic cyc(input bit wen, input bit [7:0] d, input bit ren, input bit fl);
    int pre;
    bit [7:0] x;
    i_wen = wen; i_data = d; i_ren = ren; i_flush = fl;
    @(posedge i_clk);
    pre = mq.size();
    if (fl) begin
      mq.delete();
      m_valid = 0;
    end else begin
      if (wen && pre == DEPTH) m_ovf = 1;
      if (ren && pre == 0)     m_udf = 1;
      if (ren && pre > 0) begin
        x = mq.pop_front();
        sb.push_back(x);
        m_data = x;
        m_valid = 1;
      end else m_valid = 0;
      if (wen && pre < DEPTH) mq.push_back(d);
    end
    #1;
    i_wen = 0; i_ren = 0; i_flush = 0;
  endtask

  // Monitor: pop the scoreboard whenever the DUT presents read data.
  always @(negedge i_clk) begin
    if (o_valid) begin
      if (sb.size() == 0) chk("sb_underrun", 1, 0);
      else chk("sb_data", int'(o_data), int'(sb.pop_front()));
    end
    chk_state("mon");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit [7:0] base;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1 i_rest = 0;

    // 1: reset mid-stream with 5 entries
    for (int i = 0; i < 5; i++) cyc(1, 8'($urandom), 0, 0);
    cyc(1, 8'h5A, 1, 0);
    i_rest = 1;
    model_reset();
    #1 chk_state("reset_async");
    repeat (2) @(posedge i_clk);
    #1 i_rest = 0;

    // 2: fill, then dropped 17th write
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
    cyc(1, 8'hAA, 0, 0);
    chk("fill.ovf_err", int'(o_ovf), int'(err_on()));

    // 3: drain, then 17th read on empty
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    chk("drain.last_data", int'(o_data), 8'h0F);
    chk("drain.udf_err", int'(o_udf), int'(err_on()));

    // 4: wrap with count held at 3
    base = 8'($urandom);
    for (int i = 0; i < 3; i++) cyc(1, base + 8'(i), 0, 0);
    for (int i = 3; i < 43; i++) cyc(1, base + 8'(i), 1, 0);
    chk("wrap.count", int'(o_count), 3);

    // 5: simultaneous ops on empty and full
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    cyc(1, 8'h33, 1, 0);
    chk("bnd_empty.count", int'(o_count), 1);
    chk("bnd_empty.valid", int'(o_valid), 0);
    for (int i = 0; i < 15; i++) cyc(1, 8'($urandom), 0, 0);
    cyc(1, 8'hEE, 1, 0);
    chk("bnd_full.count", int'(o_count), 15);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0);

    // 6: flush at count 9 with wen+ren
    for (int i = 0; i < 9; i++) cyc(1, 8'($urandom), 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 8'h11, 0, 0);
    base = o_data;
    cyc(1, 8'h77, 1, 1);
    chk("flush.count", int'(o_count), 0);
    chk("flush.data_hold", int'(o_data), int'(base));

    // randomized traffic, occasional flush
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 99) < 55), 8'($urandom),
          1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 2));

    cyc(0, 0, 0, 0);
    @(negedge i_clk);
    #1 chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
